// File: rtl/crc3_tx_serializer.sv
// Transmit framer: captures a 4-bit word plus its CRC-3 from the external generator
// and shifts the 7-bit codeword out with start/stop framing at BIT_CYCLES clocks per bit.
//
// state   | meaning
// S_IDLE  | line high, ready for a word
// S_START | start bit (low), one bit period
// S_DATA  | codeword bits d3..d0 c2..c0, MSB first
// S_STOP  | stop bit (high); frame counted at its end
// S_GAP   | forced idle-high periods before next word
module crc3_tx_serializer #(
   parameter int BIT_CYCLES = 1,
   parameter int IDLE_GAP   = 1,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_data,
   output logic [6:0]       gen_data,
   output logic             gen_check,
   output logic [2:0]       gen_crc_in,
   input  logic [2:0]       gen_crc,
   output logic             ser_out,
   output logic             ser_frame,
   output logic             busy,
   output logic [CNT_W-1:0] frame_count
);

   localparam int PER_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
   localparam logic [PER_W-1:0] PER_LOAD = PER_W'(BIT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_GAP
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [PER_W-1:0] per_cnt;
   logic [2:0]       bit_idx;
   logic [GAP_W-1:0] gap_cnt;
   logic [6:0]       cw;
   logic             per_tc;
   logic             accept;

   // Generator is used in generate mode only; its result is captured on the accept edge.
   assign gen_data   = {3'b000, in_data};
   assign gen_check  = 1'b1;
   assign gen_crc_in = 3'b000;

   assign in_ready = rst_n && (state == S_IDLE);
   assign accept   = in_valid && in_ready;
   assign per_tc   = (per_cnt == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept) state_nx = S_START;
         S_START: if (per_tc) state_nx = S_DATA;
         S_DATA:  if (per_tc && bit_idx == 3'd0) state_nx = S_STOP;
         S_STOP:  if (per_tc) state_nx = (IDLE_GAP > 0) ? S_GAP : S_IDLE;
         S_GAP:   if (per_tc && gap_cnt == '0) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         per_cnt     <= '0;
         bit_idx     <= '0;
         gap_cnt     <= '0;
         cw          <= '0;
         frame_count <= '0;
      end else begin
         if (state == S_IDLE) begin
            if (accept) begin
               cw      <= {in_data, gen_crc};
               per_cnt <= PER_LOAD;
               bit_idx <= 3'd6;
            end
         end else if (per_tc) begin
            per_cnt <= PER_LOAD;
         end else begin
            per_cnt <= per_cnt - 1'b1;
         end
         if (state == S_DATA && per_tc && bit_idx != 3'd0)
            bit_idx <= bit_idx - 1'b1;
         if (state == S_STOP && per_tc) begin
            frame_count <= frame_count + 1'b1;
            gap_cnt     <= GAP_LOAD;
         end
         if (state == S_GAP && per_tc && gap_cnt != '0)
            gap_cnt <= gap_cnt - 1'b1;
      end
   end

   always_comb begin
      ser_out   = 1'b1;
      ser_frame = 1'b0;
      case (state)
         S_START: begin
            ser_out   = 1'b0;
            ser_frame = 1'b1;
         end
         S_DATA: begin
            ser_out   = cw[bit_idx];
            ser_frame = 1'b1;
         end
         S_STOP:  ser_frame = 1'b1;
         default: ;
      endcase
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_crc3_tx_serializer.sv
// Directed bench for crc3_tx_serializer: three instances (1 clk/bit with gap, 3 clk/bit,
// 2-bit counter with no gap) driven by a behavioural CRC-3 generator.
module tb_crc3_tx_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_s       [3];
   logic       valid_s     [3];
   logic [3:0] data_s      [3];
   logic       ready_s     [3];
   logic [6:0] gen_data_s  [3];
   logic       gen_check_s [3];
   logic [2:0] gen_crc_in_s[3];
   logic [2:0] gen_crc_s   [3];
   logic       ser_s       [3];
   logic       frame_s     [3];
   logic       busy_s      [3];
   logic [7:0] fc_a;
   logic [7:0] fc_b;
   logic [1:0] fc_c;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural CRC-3 generator (x^3+x+1), bit-serial division MSB first.
   function automatic logic [2:0] crc3(input logic [3:0] d);
      logic [2:0] r;
      logic       fb;
      r = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         fb = d[i] ^ r[2];
         r  = {r[1], r[0] ^ fb, fb};
      end
      return r;
   endfunction

   always_comb begin
      for (int i = 0; i < 3; i++) gen_crc_s[i] = crc3(gen_data_s[i][3:0]);
   end

   crc3_tx_serializer #(.BIT_CYCLES(1), .IDLE_GAP(1), .CNT_W(8)) u_a (
      .clk(clk), .rst_n(rst_s[0]), .in_valid(valid_s[0]), .in_ready(ready_s[0]),
      .in_data(data_s[0]), .gen_data(gen_data_s[0]), .gen_check(gen_check_s[0]),
      .gen_crc_in(gen_crc_in_s[0]), .gen_crc(gen_crc_s[0]), .ser_out(ser_s[0]),
      .ser_frame(frame_s[0]), .busy(busy_s[0]), .frame_count(fc_a));

   crc3_tx_serializer #(.BIT_CYCLES(3), .IDLE_GAP(1), .CNT_W(8)) u_b (
      .clk(clk), .rst_n(rst_s[1]), .in_valid(valid_s[1]), .in_ready(ready_s[1]),
      .in_data(data_s[1]), .gen_data(gen_data_s[1]), .gen_check(gen_check_s[1]),
      .gen_crc_in(gen_crc_in_s[1]), .gen_crc(gen_crc_s[1]), .ser_out(ser_s[1]),
      .ser_frame(frame_s[1]), .busy(busy_s[1]), .frame_count(fc_b));

   crc3_tx_serializer #(.BIT_CYCLES(1), .IDLE_GAP(0), .CNT_W(2)) u_c (
      .clk(clk), .rst_n(rst_s[2]), .in_valid(valid_s[2]), .in_ready(ready_s[2]),
      .in_data(data_s[2]), .gen_data(gen_data_s[2]), .gen_check(gen_check_s[2]),
      .gen_crc_in(gen_crc_in_s[2]), .gen_crc(gen_crc_s[2]), .ser_out(ser_s[2]),
      .ser_frame(frame_s[2]), .busy(busy_s[2]), .frame_count(fc_c));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected line, one sample per clock from the accept edge: start, codeword, then high.
   function automatic logic [31:0] exp_line(input logic [6:0] cw, input int bc);
      logic [9:0]  bits;
      logic [31:0] r;
      int          p;
      bits = {1'b0, cw, 2'b11};
      r    = '1;
      p    = 31;
      for (int b = 9; b >= 0; b--) begin
         for (int c = 0; c < bc; c++) begin
            if (p >= 0) r[p] = bits[b];
            p--;
         end
      end
      return r;
   endfunction

   // Offers word d (in_ready assumed high), then samples #1 after each edge until in_ready returns.
   task automatic send(input int i, input logic [3:0] d, input logic [3:0] nd, input bit hold,
                       input bit noise, output logic [31:0] line, output int lat,
                       output int fr_clks, output bit gen_bad);
      data_s[i]  = d;
      valid_s[i] = 1'b1;
      @(posedge clk); #1;
      data_s[i]  = nd;
      valid_s[i] = hold;
      line    = '1;
      lat     = -1;
      fr_clks = 0;
      gen_bad = 1'b0;
      for (int k = 0; k < 64; k++) begin
         if (k < 32) line[31-k] = ser_s[i];
         if (frame_s[i]) fr_clks++;
         if (gen_check_s[i] !== 1'b1 || gen_crc_in_s[i] !== 3'b000) gen_bad = 1'b1;
         if (ready_s[i]) begin
            lat = k;
            break;
         end
         if (noise) begin
            valid_s[i] = 1'($urandom_range(0, 1));
            data_s[i]  = 4'($urandom_range(0, 15));
         end
         @(posedge clk); #1;
      end
      if (noise) valid_s[i] = 1'b0;
   endtask

   logic [31:0] line;
   int          lat;
   int          frc;
   bit          gbad;

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst_s[i]   = 1'b0;
         valid_s[i] = 1'b0;
         data_s[i]  = 4'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready_s[0]), 32'd0);
      chk("rst_ser", 32'(ser_s[0]), 32'd1);
      chk("rst_frame", 32'(frame_s[0]), 32'd0);
      chk("rst_busy", 32'(busy_s[0]), 32'd0);
      chk("rst_fc", 32'(fc_a), 32'd0);
      for (int i = 0; i < 3; i++) rst_s[i] = 1'b1;
      #1;
      chk("rel_ready", 32'(ready_s[0]), 32'd1);
      data_s[0] = 4'b1010;
      #1;
      chk("gen_data", 32'(gen_data_s[0]), 32'h0A);

      // single frame, 1 clk/bit, one gap period
      send(0, 4'b1101, 4'b0000, 1'b0, 1'b0, line, lat, frc, gbad);
      chk("a1_line", line, exp_line(7'b1101001, 1));
      chk("a1_lat", 32'(lat), 32'd10);
      chk("a1_frame", 32'(frc), 32'd9);
      chk("a1_fc", 32'(fc_a), 32'd1);

      // input noise while busy must not disturb the in-flight codeword
      send(0, 4'b1111, 4'b0000, 1'b0, 1'b1, line, lat, frc, gbad);
      chk("noise_line", line, exp_line(7'b1111111, 1));
      chk("noise_lat", 32'(lat), 32'd10);
      chk("noise_fc", 32'(fc_a), 32'd2);
      chk("noise_gen", 32'(gbad), 32'd0);

      // reset during DATA bit index 3
      data_s[0]  = 4'b1101;
      valid_s[0] = 1'b1;
      @(posedge clk); #1;
      valid_s[0] = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("mid_bit3", 32'(ser_s[0]), 32'd1);
      rst_s[0] = 1'b0;
      #1;
      chk("mid_ready_rst", 32'(ready_s[0]), 32'd0);
      @(posedge clk); #1;
      chk("mid_ser", 32'(ser_s[0]), 32'd1);
      chk("mid_frame", 32'(frame_s[0]), 32'd0);
      chk("mid_busy", 32'(busy_s[0]), 32'd0);
      chk("mid_fc", 32'(fc_a), 32'd0);
      rst_s[0] = 1'b1;
      #1;
      send(0, 4'b0110, 4'b0000, 1'b0, 1'b0, line, lat, frc, gbad);
      chk("post_line", line, exp_line(7'b0110001, 1));
      chk("post_fc", 32'(fc_a), 32'd1);

      // 3 clocks per bit
      send(1, 4'b1101, 4'b0000, 1'b0, 1'b0, line, lat, frc, gbad);
      chk("b_line", line, exp_line(7'b1101001, 3));
      chk("b_lat", 32'(lat), 32'd30);
      chk("b_frame", 32'(frc), 32'd27);
      chk("b_fc", 32'(fc_b), 32'd1);

      // no gap: back-to-back with in_valid held, 2-bit frame counter wrap
      send(2, 4'b0001, 4'b0000, 1'b1, 1'b0, line, lat, frc, gbad);
      chk("c1_line", line, exp_line(7'b0001011, 1));
      chk("c1_accept_gap", 32'(lat + 1), 32'd10);
      chk("c1_fc", 32'(fc_c), 32'd1);
      send(2, 4'b0000, 4'b1000, 1'b1, 1'b0, line, lat, frc, gbad);
      chk("c2_line", line, exp_line(7'b0000000, 1));
      chk("c2_accept_gap", 32'(lat + 1), 32'd10);
      chk("c2_fc", 32'(fc_c), 32'd2);
      send(2, 4'b1000, 4'b0010, 1'b1, 1'b0, line, lat, frc, gbad);
      chk("c3_line", line, exp_line(7'b1000101, 1));
      chk("c3_fc", 32'(fc_c), 32'd3);
      send(2, 4'b0010, 4'b0000, 1'b0, 1'b0, line, lat, frc, gbad);
      chk("c4_line", line, exp_line(7'b0010110, 1));
      chk("c4_fc", 32'(fc_c), 32'd0);
      send(2, 4'b1111, 4'b0000, 1'b0, 1'b0, line, lat, frc, gbad);
      chk("c5_line", line, exp_line(7'b1111111, 1));
      chk("c5_fc", 32'(fc_c), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/crc3_tx_serializer.md
Name: crc3_tx_serializer

Overview:
Transmit-side framer that sits directly downstream of the combinational CRC-3 generate/check block (polynomial x^3+x+1, 4-bit data, 3-bit remainder).
- Accepts 4-bit data words on a valid/ready handshake.
- Drives the generator in generate mode and appends the returned 3-bit CRC to form a 7-bit codeword.
- Shifts the codeword out on a single serial line with start/stop framing and a configurable bit period.

Parameters:
- BIT_CYCLES, 1: clocks per serial bit (>=1).
- IDLE_GAP, 1: extra idle bit periods forced after each stop bit (>=0).
- CNT_W, 8: width of frame_count.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  data word available.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  4  data word.
- gen_data  out  7  to generator data input; = {3'b000, in_data}, combinational pass-through.
- gen_check  out  1  to generator mode select; constant 1 (generate).
- gen_crc_in  out  3  to generator crc input; constant 3'b000.
- gen_crc  in  3  CRC from generator (combinational from gen_data).
- ser_out  out  1  serial line; idles high.
- ser_frame  out  1  high from start bit through stop bit.
- busy  out  1  high in any state other than IDLE.
- frame_count  out  CNT_W  completed frames, wraps modulo 2^CNT_W.

Behaviour:
- States: IDLE, START, DATA, STOP, GAP. All outputs except the gen_* pass-throughs are registered or decoded from the state register.
- Reset: while rst_n is low at a rising edge, the next state is IDLE.
  - ser_out=1, ser_frame=0, frame_count=0, bit counter and period counter=0.
  - in_ready=0 during reset; in_ready=1 from the first cycle after release.
- in_ready = (state==IDLE).
- Accept occurs when in_valid && in_ready at an edge. On accept:
  - shift register <= {in_data, gen_crc} (zero-latency capture through the generator).
  - state <= START; ser_out <= 0; ser_frame <= 1.
- in_valid while not ready: ignored; no accept, no stall of the current frame.
- Period counter: each state holds for BIT_CYCLES clocks per bit, then advances.
- START: ser_out=0 for one bit period, then DATA.
- DATA: transmits 7 bits MSB first, in the order d3 d2 d1 d0 c2 c1 c0, each held one bit period. A 3-bit bit index counts 6 down to 0. After bit 0, go to STOP.
- STOP: ser_out=1, ser_frame=1 for one bit period.
  - At the end of the period: frame_count increments and ser_frame drops.
  - Next state is GAP if IDLE_GAP>0, else IDLE.
- GAP: ser_out=1, ser_frame=0 for IDLE_GAP bit periods, then IDLE.
- Frame length from the accept edge to the return of in_ready: (9+IDLE_GAP)*BIT_CYCLES clocks.
- Back-to-back words: with IDLE_GAP=0, a new word can be accepted on the first IDLE cycle after STOP. The minimum idle-high time on the line is then 1 clock.
- Reset mid-frame: the frame is abandoned and not counted. ser_out returns to 1 at the next edge.
- frame_count at its maximum value wraps to 0 on the next completed frame.
- in_data may change freely after the accept edge; the shift register holds the codeword.

Test Plan:
1. BIT_CYCLES=1, IDLE_GAP=1, send in_data=4'b1101.
   -> ser_out after accept is 0,1,1,0,1,0,0,1,1 then 1 (gap); codeword 1101001 (crc=001).
   -> in_ready returns 10 clocks after accept; frame_count=1.
2. Send 4'b0001 and 4'b0000 back-to-back with in_valid held high.
   -> codewords 0001011 and 0000000.
   -> second accept occurs exactly 10 clocks after the first; frame_count=2.
3. BIT_CYCLES=3, send 4'b1101.
   -> each bit is held 3 clocks; ser_frame is high for 27 clocks; in_ready returns after 30 clocks.
4. Assert rst_n=0 for 1 cycle during DATA bit 3.
   -> next cycle: ser_out=1, ser_frame=0, busy=0, frame_count=0.
   -> the following word is transmitted correctly.
5. Toggle in_valid and in_data randomly while busy.
   -> no extra accepts; the in-flight codeword is unchanged.
   -> gen_check=1 and gen_crc_in=000 throughout.
6. CNT_W=2, send 5 frames -> frame_count sequence is 1,2,3,0,1.
